pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand and sum width; SHALL be >= 2.
REQ-002 Parameter SEG_WIDTH, default 4, bits added per pipeline stage; SHALL be 1..DATA_WIDTH; NSEG = ceil(DATA_WIDTH/SEG_WIDTH).
REQ-003 clk  in  1  single clock; all state SHALL update on the posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  operand set present.
REQ-006 in_ready  out  1  block accepts operand set this cycle.
REQ-007 ain, bin  in  DATA_WIDTH each  operands, unsigned or two's complement.
REQ-008 cin  in  1  carry-in (add) / borrow-in (sub).
REQ-009 op  in  1  0 = add, 1 = subtract (pipe_adder_pkg::op_e).
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 sout  out  DATA_WIDTH  result; cout  out  1  carry-out; ovf  out  1  signed overflow.

Function
REQ-013 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-014 Add SHALL produce {cout,sout} = ain + bin + cin (DATA_WIDTH+1 bits).
REQ-015 Subtract SHALL produce {cout,sout} = ain + ~bin + ~cin, i.e. sout = ain - bin - cin; cout=1 means no borrow.
REQ-016 ovf SHALL be 1 iff the sign bits of ain and the effective second operand (bin or ~bin) are equal and differ from sout's sign bit.
REQ-017 Datapath SHALL be one input register stage plus NSEG segment stages; segment k adds bits [k*SEG_WIDTH +: SEG_WIDTH] with the carry registered from segment k-1 (segment 0 takes cin, inverted for sub).
REQ-018 Unprocessed upper operand bits and completed lower sum bits SHALL be carried forward (skewed) so each result is coherent.
REQ-019 The last segment SHALL be DATA_WIDTH - (NSEG-1)*SEG_WIDTH bits wide when DATA_WIDTH is not a multiple of SEG_WIDTH.
REQ-020 Latency SHALL be exactly NSEG+1 cycles from input transfer to out_valid when out_ready is held 1.
REQ-021 Throughput SHALL be one result per cycle with in_valid and out_ready continuously 1.
REQ-022 Each stage SHALL carry a valid bit; stage advance enable = !out_valid || out_ready; all stages SHALL stall together when the enable is 0.
REQ-023 in_ready SHALL equal the advance enable; in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 While out_valid=1 and out_ready=0, sout, cout, ovf SHALL hold stable.
REQ-025 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-026 A cycle with in_valid=0 and enable=1 SHALL insert a bubble (stage valid=0).
REQ-027 op SHALL be sampled per operand set; mixed add/sub back-to-back SHALL be correct.

Reset
REQ-028 On rst=1, all stage valid bits and out_valid SHALL clear to 0 immediately, without clk.
REQ-029 sout, cout, ovf SHALL reset to 0; data registers beyond valid bits MAY reset to 0.
REQ-030 In-flight operations at reset SHALL be discarded; the first result after deassertion SHALL come from the first post-reset input transfer.
REQ-031 in_ready SHALL be 1 during and after reset (pipeline empty).

Structure
REQ-032 Package pipe_adder_pkg SHALL hold typedef op_e {OP_ADD, OP_SUB} and function nseg(width, seg) returning the ceiling division.
REQ-033 One segment stage SHALL be a sub-module pipe_adder_seg (parameter W; inputs a, b, carry-in, enable; registered sum slice and carry-out), instantiated NSEG times via generate.

Verification (DATA_WIDTH=16, SEG_WIDTH=4 unless noted; latency 5)
REQ-034 Add 0xFFFF+0x0001, cin=0 -> sout=0x0000, cout=1, ovf=0 exactly 5 cycles after transfer.
REQ-035 Add 0x7FFF+0x0001, cin=0 -> sout=0x8000, cout=0, ovf=1; Sub 0x0000-0x0001, cin=0 -> sout=0xFFFF, cout=0, ovf=0.
REQ-036 20 back-to-back random mixed add/sub ops, out_ready=0 for cycles 8-10 -> in_ready=0 in those cycles, outputs stable, all 20 results correct and in order.
REQ-037 rst pulsed asynchronously between clock edges with 3 ops in flight -> out_valid drops at once, no stale result after release; next op 0x1234+0x1111 -> 0x2345.
REQ-038 DATA_WIDTH=18, SEG_WIDTH=4 (NSEG=5, last slice 2 bits): 0x3FFFF+0x00001 -> sout=0x00000, cout=1 at latency 6.
REQ-039 Random regression of >=10000 ops against a reference model for (16,4), (16,16), (18,4), with random in_valid/out_ready gaps -> zero mismatches.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the segmented pipelined adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of segment stages needed to cover 'width' bits in 'seg'-bit slices.
    function automatic int nseg(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// One adder segment: registers a W-bit slice sum and its carry-out.
// Latency: 1 cycle.
// Backpressure: holds its registers whenever en_i is low.
module pipe_adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);

    logic [W:0]   sum_d;
    logic [W-1:0] s_q;
    logic         co_q;

    // Slice sum with one extra bit that becomes the carry into the next segment.
    always_comb begin
        sum_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
    end

    // Capture the slice result only when the whole pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else if (en_i) begin
            {co_q, s_q} <= sum_d;
        end
    end

    assign s_o  = s_q;
    assign co_o = co_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, carry rippled across NSEG registered segments.
// Latency: NSEG+1 cycles (input register plus one register per segment).
// Backpressure: every stage stalls together while out_valid && !out_ready.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SEG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ain,
    input  logic [DATA_WIDTH-1:0] bin,
    input  logic                  cin,
    input  op_e                   op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sout,
    output logic                  cout,
    output logic                  ovf
);

    localparam int DW   = DATA_WIDTH;
    localparam int NSEG = nseg(DATA_WIDTH, SEG_WIDTH);

    // Pipeline advance enable shared by every stage.
    logic en;

    // Input stage: operands with subtraction already folded into b and carry.
    logic          vin_q;
    logic          c0_q;
    logic [DW-1:0] b_d;
    logic          c_d;

    // Per-segment operand copies (index k feeds segment k); skewed so each
    // segment sees the operand set it belongs to.
    logic [DW-1:0] a_q [NSEG];
    logic [DW-1:0] b_q [NSEG];

    // Per-segment state aligned with segment k's output registers.
    logic [NSEG-1:0] v_q;
    logic [DW-1:0]   fs_q  [NSEG];   // completed lower sum bits carried forward
    logic [1:0]      sgn_q [NSEG];   // {sign of a, sign of effective b}
    logic [DW-1:0]   sum_v [NSEG];   // forwarded bits merged with segment k's slice
    logic            co    [NSEG];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is a + ~b + ~borrow, so invert b and the incoming carry here.
    always_comb begin
        b_d = (op == OP_SUB) ? ~bin : bin;
        c_d = (op == OP_SUB) ? ~cin : cin;
    end

    // Advance all stage registers together; a missing input becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vin_q <= 1'b0;
            c0_q  <= 1'b0;
            v_q   <= '0;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                fs_q[k]  <= '0;
                sgn_q[k] <= '0;
            end
        end else if (en) begin
            vin_q    <= in_valid;
            a_q[0]   <= ain;
            b_q[0]   <= b_d;
            c0_q     <= c_d;
            v_q[0]   <= vin_q;
            fs_q[0]  <= '0;
            sgn_q[0] <= {a_q[0][DW-1], b_q[0][DW-1]};
            for (int k = 1; k < NSEG; k++) begin
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                v_q[k]   <= v_q[k-1];
                fs_q[k]  <= sum_v[k-1];
                sgn_q[k] <= sgn_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int OFF = k * SEG_WIDTH;
        // The top slice absorbs whatever is left when widths do not divide.
        localparam int W = (k == NSEG - 1) ? (DW - OFF) : SEG_WIDTH;
        localparam logic [DW-1:0] MASK = ({DW{1'b1}} >> (DW - W)) << OFF;

        logic [W-1:0] s;
        logic         ci;

        if (k == 0) begin : g_first
            assign ci = c0_q;
        end else begin : g_rest
            assign ci = co[k-1];
        end

        pipe_adder_seg #(
            .W(W)
        ) u_seg (
            .clk  (clk),
            .rst  (rst),
            .en_i (en),
            .a_i  (a_q[k][OFF +: W]),
            .b_i  (b_q[k][OFF +: W]),
            .ci_i (ci),
            .s_o  (s),
            .co_o (co[k])
        );

        assign sum_v[k] = (fs_q[k] & ~MASK) | (DW'(s) << OFF);
    end

    assign out_valid = v_q[NSEG-1];
    assign sout      = sum_v[NSEG-1];
    assign cout      = co[NSEG-1];
    // Overflow when both addends share a sign that the result does not.
    assign ovf       = (sgn_q[NSEG-1][1] == sgn_q[NSEG-1][0]) &&
                       (sum_v[NSEG-1][DW-1] != sgn_q[NSEG-1][1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder in three configurations: (16,4), (16,16), (18,4).
// Latency: n/a.
// Backpressure: bench drives out_ready patterns and random stalls.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid [3];
    logic        in_ready [3];
    logic        cin      [3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic        cout     [3];
    logic        ovf      [3];
    logic [17:0] ain      [3];
    logic [17:0] bin      [3];
    op_e         op       [3];
    logic [17:0] sout     [3];
    logic [15:0] s0, s1;
    logic [17:0] s2;

    assign sout[0] = {2'b00, s0};
    assign sout[1] = {2'b00, s1};
    assign sout[2] = s2;

    int n_chk  = 0;
    int n_fail = 0;
    logic [19:0] sb_q[$];

    pipe_adder #(.DATA_WIDTH(16), .SEG_WIDTH(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .ain(ain[0][15:0]), .bin(bin[0][15:0]), .cin(cin[0]), .op(op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sout(s0), .cout(cout[0]), .ovf(ovf[0]));

    pipe_adder #(.DATA_WIDTH(16), .SEG_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .ain(ain[1][15:0]), .bin(bin[1][15:0]), .cin(cin[1]), .op(op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sout(s1), .cout(cout[1]), .ovf(ovf[1]));

    pipe_adder #(.DATA_WIDTH(18), .SEG_WIDTH(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .ain(ain[2]), .bin(bin[2]), .cin(cin[2]), .op(op[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sout(s2), .cout(cout[2]), .ovf(ovf[2]));

    function automatic int width_of(input int d);
        return (d == 2) ? 18 : 16;
    endfunction

    // Reference: {ovf, cout, sout} straight from the arithmetic definition.
    function automatic logic [19:0] model(input int w, input logic [17:0] a,
                                          input logic [17:0] b, input logic c,
                                          input logic sub);
        logic [18:0] m, av, bv, tot;
        logic        ov;
        m   = (19'd1 << w) - 19'd1;
        av  = {1'b0, a} & m;
        bv  = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
        tot = av + bv + {18'd0, (sub ? ~c : c)};
        ov  = (av[w-1] == bv[w-1]) && (tot[w-1] != av[w-1]);
        return {ov, tot[w], tot[17:0] & m[17:0]};
    endfunction

    task automatic drive(input int d, input logic v, input logic [17:0] a,
                         input logic [17:0] b, input logic c, input logic sub);
        in_valid[d] = v;
        ain[d]      = a;
        bin[d]      = b;
        cin[d]      = c;
        op[d]       = sub ? OP_SUB : OP_ADD;
    endtask

    task automatic drive_rand(input int d);
        logic [17:0] m;
        m = 18'((19'd1 << width_of(d)) - 19'd1);
        drive(d, 1'b1, 18'($urandom) & m, 18'($urandom) & m,
              1'($urandom), 1'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (out_valid[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, out_valid[d]);
            end
            n_chk++;
            if (in_ready[d] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, in_ready[d]);
            end
            n_chk++;
            if ({ovf[d], cout[d], sout[d]} !== 20'h0) begin
                n_fail++; $display("FAIL reset_outputs[%0d]: got %h expected 0", d, {ovf[d], cout[d], sout[d]});
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single operations on an idle pipe: exact latency and boundary results.
    task automatic test_directed();
        int          td [5] = '{0, 0, 0, 2, 1};
        logic [17:0] ta [5] = '{18'h0FFFF, 18'h07FFF, 18'h00000, 18'h3FFFF, 18'h07FFF};
        logic        tsb[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          tl [5] = '{5, 5, 5, 6, 2};
        logic [19:0] te [5] = '{{1'b0, 1'b1, 18'h00000}, {1'b1, 1'b0, 18'h08000},
                               {1'b0, 1'b0, 18'h0FFFF}, {1'b0, 1'b1, 18'h00000},
                               {1'b1, 1'b0, 18'h08000}};
        for (int i = 0; i < 5; i++) begin
            int          d = td[i];
            int          first = -1;
            logic [19:0] got = 'x;
            @(posedge clk); #1;
            out_ready[d] = 1'b1;
            drive(d, 1'b1, ta[i], 18'h00001, 1'b0, tsb[i]);
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge clk);
                if (out_valid[d] && first < 0) begin
                    first = cyc;
                    got   = {ovf[d], cout[d], sout[d]};
                end
                @(posedge clk); #1;
                in_valid[d] = 1'b0;
            end
            n_chk++;
            if (first != tl[i]) begin
                n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, first, tl[i]);
            end
            n_chk++;
            if (got !== te[i]) begin
                n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, got, te[i]);
            end
        end
    endtask

    // 20 continuous mixed ops with out_ready low in cycles 8..10.
    task automatic test_back_to_back();
        int          sent = 1, recv = 0, last_pop = -1;
        logic        acc;
        logic [19:0] held = '0, act, exp;
        sb_q.delete();
        @(posedge clk); #1;
        drive_rand(0);
        for (int cyc = 0; cyc < 60 && recv < 20; cyc++) begin
            out_ready[0] = !(cyc >= 8 && cyc <= 10);
            @(negedge clk);
            act = {ovf[0], cout[0], sout[0]};
            if (cyc >= 8 && cyc <= 10) begin
                n_chk++;
                if (in_ready[0] !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_in_ready_cycle%0d: got %b expected 0", cyc, in_ready[0]);
                end
            end
            if (cyc == 8) held = act;
            if (cyc == 9 || cyc == 10) begin
                n_chk++;
                if (act !== held) begin
                    n_fail++; $display("FAIL b2b_hold_cycle%0d: got %h expected %h", cyc, act, held);
                end
            end
            acc = in_valid[0] && in_ready[0];
            if (acc) sb_q.push_back(model(16, ain[0], bin[0], cin[0], op[0] == OP_SUB));
            if (out_valid[0] && out_ready[0]) begin
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                n_chk++;
                if (act !== exp) begin
                    n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", recv, act, exp);
                end
                recv++;
                last_pop = cyc;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (sent < 20) begin drive_rand(0); sent++; end
                else in_valid[0] = 1'b0;
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        n_chk++;
        if (recv != 20) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 20", recv);
        end
        n_chk++;
        if (last_pop != 27) begin
            n_fail++; $display("FAIL b2b_last_cycle: got %0d expected 27", last_pop);
        end
    endtask

    // Asynchronous reset with results in flight, then one clean op.
    task automatic test_reset_inflight();
        int          stale = 0, first = -1;
        logic [19:0] got = 'x;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(0);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (out_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_valid: got %b expected 0", out_valid[0]);
        end
        n_chk++;
        if (in_ready[0] !== 1'b1 || {ovf[0], cout[0], sout[0]} !== 20'h0) begin
            n_fail++; $display("FAIL rst_async_outputs: got ready %b data %h expected ready 1 data 0",
                               in_ready[0], {ovf[0], cout[0], sout[0]});
        end
        @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (out_valid[0]) stale++;
        end
        n_chk++;
        if (stale != 0) begin
            n_fail++; $display("FAIL rst_stale_results: got %0d expected 0", stale);
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 18'h01234, 18'h01111, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid[0] && first < 0) begin
                first = cyc;
                got   = {ovf[0], cout[0], sout[0]};
            end
            @(posedge clk); #1;
            in_valid[0] = 1'b0;
        end
        n_chk++;
        if (first != 5 || got !== {2'b00, 18'h02345}) begin
            n_fail++; $display("FAIL rst_first_op: got latency %0d data %h expected latency 5 data %h",
                               first, got, {2'b00, 18'h02345});
        end
    endtask

    // Random gaps on both sides against the reference model.
    task automatic test_regression(input int d, input int n);
        int          sent = 0, recv = 0;
        logic        acc, hold = 1'b0;
        logic [19:0] held = '0, act, exp;
        sb_q.delete();
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        for (int cyc = 0; cyc < n * 4 && recv < n; cyc++) begin
            if (!in_valid[d] && sent < n && $urandom_range(0, 9) < 8) drive_rand(d);
            out_ready[d] = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            act = {ovf[d], cout[d], sout[d]};
            if (hold) begin
                n_chk++;
                if (act !== held) begin
                    n_fail++; $display("FAIL regr%0d_hold: got %h expected %h", d, act, held);
                end
            end
            hold = out_valid[d] && !out_ready[d];
            held = act;
            acc  = in_valid[d] && in_ready[d];
            if (acc) begin
                sb_q.push_back(model(width_of(d), ain[d], bin[d], cin[d], op[d] == OP_SUB));
                sent++;
            end
            if (out_valid[d] && out_ready[d]) begin
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                n_chk++;
                if (act !== exp) begin
                    n_fail++; $display("FAIL regr%0d_result[%0d]: got %h expected %h", d, recv, act, exp);
                end
                recv++;
            end
            @(posedge clk); #1;
            if (acc) in_valid[d] = 1'b0;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        n_chk++;
        if (recv != n) begin
            n_fail++; $display("FAIL regr%0d_count: got %0d expected %0d", d, recv, n);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 18'h0, 18'h0, 1'b0, 1'b0);
            out_ready[d] = 1'b1;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_regression(0, 10000);
        test_regression(1, 10000);
        test_regression(2, 10000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
